// File: rtl/tt_ihp_oe_sequencer.sv
// Pad output-enable sequencer for the IHP GPIO ring.
// Break-before-make with dead time and group-staggered re-enable.
module tt_ihp_oe_sequencer #(
    parameter int N_PADS      = 48,
    parameter int GROUP       = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int STEP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_PADS-1:0] cfg_oe,
    input  logic              kill,
    input  logic [N_PADS-1:0] core_oe,
    output logic [N_PADS-1:0] pad_oe,
    output logic              busy
);

    localparam int NGROUPS = (N_PADS + GROUP - 1) / GROUP;
    localparam int CMAX = (DEAD_CYCLES > STEP_CYCLES) ?
                          DEAD_CYCLES : STEP_CYCLES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int GW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_DEAD,
        S_RAMP
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [GW-1:0]     r_grp;
    logic [N_PADS-1:0] r_mask;
    logic [N_PADS-1:0] r_gate;
    logic [N_PADS-1:0] r_pad;
    logic              r_busy;
    logic              w_accept;

    assign cfg_ready = (r_state == S_IDLE) && !kill;
    assign w_accept  = cfg_valid && cfg_ready;
    assign pad_oe    = r_pad;
    assign busy      = r_busy;

    // Sequencer FSM: break, dead-time hold, then staggered group enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grp   <= '0;
            r_mask  <= '0;
            r_gate  <= '0;
            r_busy  <= 1'b0;
        end else if (kill) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grp   <= '0;
            r_gate  <= '0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mask  <= cfg_oe;
                        r_state <= S_BREAK;
                        r_busy  <= 1'b1;
                    end
                end
                S_BREAK: begin
                    r_gate  <= '0;
                    r_cnt   <= CW'(DEAD_CYCLES - 1);
                    r_state <= S_DEAD;
                end
                S_DEAD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_grp   <= '0;
                        r_cnt   <= CW'(STEP_CYCLES - 1);
                        r_state <= S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        for (int i = 0; i < N_PADS; i++) begin
                            if ((i / GROUP) == int'(r_grp)) begin
                                r_gate[i] <= r_mask[i];
                            end
                        end
                        if (r_grp == GW'(NGROUPS - 1)) begin
                            r_grp   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_grp <= r_grp + GW'(1);
                            r_cnt <= CW'(STEP_CYCLES - 1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pad enables: core request qualified by the previous cycle's gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pad <= '0;
        end else begin
            r_pad <= core_oe & r_gate;
        end
    end

endmodule

// File: tb/tb_tt_ihp_oe_sequencer.sv
// Randomized self-checking bench for tt_ihp_oe_sequencer.
// Two instances: default 48 pads and a 20-pad partial-group variant.
module tb_tt_ihp_oe_sequencer;

    localparam int GROUP = 8;
    localparam int DEAD  = 4;
    localparam int STEP  = 2;

    logic        clk = 1'b0;
    logic        rst_n_a;
    logic        rst_n_b;
    logic        cfg_valid;
    logic        kill;
    logic [47:0] cfg_oe;
    logic [47:0] core_oe;
    logic        rdy_a, busy_a;
    logic        rdy_b, busy_b;
    logic [47:0] pad_a;
    logic [19:0] pad_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tt_ihp_oe_sequencer u_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .cfg_valid (cfg_valid),
        .cfg_ready (rdy_a),
        .cfg_oe    (cfg_oe),
        .kill      (kill),
        .core_oe   (core_oe),
        .pad_oe    (pad_a),
        .busy      (busy_a)
    );

    tt_ihp_oe_sequencer #(
        .N_PADS      (20),
        .GROUP       (GROUP),
        .DEAD_CYCLES (DEAD),
        .STEP_CYCLES (STEP)
    ) u_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .cfg_valid (cfg_valid),
        .cfg_ready (rdy_b),
        .cfg_oe    (cfg_oe[19:0]),
        .kill      (kill),
        .core_oe   (core_oe[19:0]),
        .pad_oe    (pad_b),
        .busy      (busy_b)
    );

    // Reference: time since accept decides which groups are released.
    typedef struct {
        logic        act;
        int          s;
        logic [47:0] mask;
        logic [47:0] gate;
        logic [47:0] pad;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.act  = 1'b0;
        z.s    = 0;
        z.mask = '0;
        z.gate = '0;
        z.pad  = '0;
        return z;
    endfunction

    function automatic mdl_t mstep(
        input mdl_t        m,
        input int          np,
        input logic        k,
        input logic        v,
        input logic [47:0] cfg,
        input logic [47:0] core
    );
        mdl_t        n;
        int          ng;
        int          tt;
        logic [47:0] lim;
        n   = m;
        ng  = (np + GROUP - 1) / GROUP;
        tt  = 1 + DEAD + ng * STEP;
        lim = (48'd1 << np) - 48'd1;
        n.pad = core & m.gate & lim;
        if (k) begin
            n.gate = '0;
            n.act  = 1'b0;
        end else if (m.act) begin
            n.s = m.s + 1;
            for (int i = 0; i < np; i++) begin
                if (n.s >= 1 + DEAD + (i / GROUP + 1) * STEP)
                    n.gate[i] = m.mask[i];
                else
                    n.gate[i] = 1'b0;
            end
            if (n.s == tt) n.act = 1'b0;
        end else if (v) begin
            n.act  = 1'b1;
            n.s    = 0;
            n.mask = cfg & lim;
        end
        return n;
    endfunction

    task automatic check(
        input string       tag,
        input logic [47:0] got,
        input logic [47:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cmp_all();
        check("a_pad",  pad_a, ma.pad);
        check("a_busy", 48'(busy_a), 48'(ma.act));
        check("a_rdy",  48'(rdy_a), 48'(!ma.act && !kill));
        check("b_pad",  {28'd0, pad_b}, mb.pad);
        check("b_busy", 48'(busy_b), 48'(mb.act));
        check("b_rdy",  48'(rdy_b), 48'(!mb.act && !kill));
    endtask

    task automatic cyc();
        if (rst_n_a)
            ma = mstep(ma, 48, kill, cfg_valid, cfg_oe, core_oe);
        if (rst_n_b)
            mb = mstep(mb, 20, kill, cfg_valid, cfg_oe, core_oe);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int na;
        int nb;
        ma = mdl_zero();
        mb = mdl_zero();
        rst_n_a   = 1'b0;
        rst_n_b   = 1'b0;
        cfg_valid = 1'b0;
        kill      = 1'b0;
        cfg_oe    = '0;
        core_oe   = '1;
        run(3);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        run(6);

        // Full mask; measure busy length on both instances.
        cfg_valid = 1'b1;
        cfg_oe    = 48'hFFFF_FFFF_FFFF;
        cyc();
        cfg_valid = 1'b0;
        na = 0;
        nb = 0;
        for (int i = 0; i < 25; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            cyc();
        end
        check("a_busy_len", 48'(na), 48'd17);
        check("b_busy_len", 48'(nb), 48'd11);

        // Narrow mask from all-enabled.
        cfg_valid = 1'b1;
        cfg_oe    = 48'h0000_00FF_0000;
        cyc();
        cfg_valid = 1'b0;
        run(22);

        // Second offer held through busy.
        cfg_valid = 1'b1;
        cfg_oe    = 48'h0F0F_0F0F_0F0F;
        cyc();
        cfg_oe    = 48'hA5A5_5A5A_C3C3;
        run(20);
        cfg_valid = 1'b0;
        run(20);

        // Kill after three groups are live.
        cfg_valid = 1'b1;
        cfg_oe    = 48'hFFFF_FFFF_FFFF;
        cyc();
        cfg_valid = 1'b0;
        run(12);
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        run(4);

        // Async reset of the 20-pad instance in DEAD, then in RAMP.
        cfg_valid = 1'b1;
        cfg_oe    = 48'hFFFF_FFFF_FFFF;
        cyc();
        cfg_valid = 1'b0;
        run(3);
        rst_n_b = 1'b0;
        #1;
        mb = mdl_zero();
        check("b_arst_dead_busy", 48'(busy_b), 48'd0);
        check("b_arst_dead_rdy",  48'(rdy_b), 48'd1);
        check("b_arst_dead_pad",  {28'd0, pad_b}, 48'd0);
        run(2);
        rst_n_b = 1'b1;
        run(30);
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        run(9);
        rst_n_b = 1'b0;
        #1;
        mb = mdl_zero();
        check("b_arst_ramp_pad",  {28'd0, pad_b}, 48'd0);
        check("b_arst_ramp_busy", 48'(busy_b), 48'd0);
        run(2);
        rst_n_b = 1'b1;
        run(25);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if (!cfg_valid) begin
                cfg_valid = ($urandom_range(0, 5) == 0);
                if (cfg_valid)
                    cfg_oe = {$urandom(), $urandom()};
            end else if (rdy_a) begin
                cfg_valid = $urandom_range(0, 1);
            end
            kill = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 3) == 0)
                core_oe = '1;
            else
                core_oe = {$urandom(), $urandom()};
            cyc();
        end
        kill      = 1'b0;
        cfg_valid = 1'b0;
        run(25);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
